// File: rtl/picorv32_mem_arbiter.sv
// rtl/picorv32_mem_arbiter.sv - two-master arbiter sharing one picorv32 native memory port
//
// Purpose: grants one of two picorv32 native-port masters (m0, m1) access to a
// single shared memory port. One transaction is in flight at a time and the
// grant is held from request until completion. Arbitration costs one IDLE cycle.
// FIXED_PRIO = 0 alternates on simultaneous requests, FIXED_PRIO = 1 favours m0.
// Optional feature macro: MEM_ARB_TIMEOUT_EN adds the TIMEOUT_CYCLES parameter,
// an abort counter and the sticky timeout_err output.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   m0_* / m1_*     master ports: valid/instr/addr/wdata/wstrb in, ready/rdata out
//   s_*             shared port: valid/instr/addr/wdata/wstrb out, ready/rdata in
//   timeout_err     sticky abort flag (MEM_ARB_TIMEOUT_EN only)
//   grant           one-hot current owner, 2'b00 when idle

module picorv32_mem_arbiter #(
    parameter int FIXED_PRIO = 0
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic        timeout_err,
`endif
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant;    // 0: m0 owned the last transaction, 1: m1
    logic        pick1;         // arbitration result while IDLE
    logic        busy;
    logic        done;
    logic        timeout_hit;
    logic        instr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    assign busy = (state != IDLE);
    assign done = busy && (s_ready || timeout_hit);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt;

    // A real s_ready on the limit cycle takes precedence over the abort.
    assign timeout_hit = busy && !s_ready && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            // Held at zero while IDLE, so every transaction starts counting from 0.
            if (!busy) begin
                wait_cnt <= '0;
            end else if (!s_ready && !timeout_hit) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            if (done) begin
                last_grant <= (state == BUSY1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        pick1      = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    // Round-robin hands the tie to whoever did not go last.
                    pick1 = (FIXED_PRIO == 0) && !last_grant;
                end else begin
                    pick1 = m1_valid;
                end
                if (m0_valid || m1_valid) begin
                    state_next = pick1 ? BUSY1 : BUSY0;
                end
            end
            BUSY0, BUSY1: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request is frozen on the granting edge so master activity cannot disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (!busy && (state_next != IDLE)) begin
            instr_q <= pick1 ? m1_instr : m0_instr;
            addr_q  <= pick1 ? m1_addr  : m0_addr;
            wdata_q <= pick1 ? m1_wdata : m0_wdata;
            wstrb_q <= pick1 ? m1_wstrb : m0_wstrb;
        end
    end

    // Output logic; readies are combinational from s_ready, so reset clears them at once.
    always_comb begin
        s_valid  = busy;
        grant    = {state == BUSY1, state == BUSY0};
        s_instr  = instr_q;
        s_addr   = addr_q;
        s_wdata  = wdata_q;
        s_wstrb  = wstrb_q;
        m0_ready = (state == BUSY0) && (s_ready || timeout_hit);
        m1_ready = (state == BUSY1) && (s_ready || timeout_hit);
        // An aborted transaction returns zero data.
        m0_rdata = ((state == BUSY0) && s_ready) ? s_rdata : 32'h0000_0000;
        m1_rdata = ((state == BUSY1) && s_ready) ? s_rdata : 32'h0000_0000;
    end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb/tb_picorv32_mem_arbiter.sv - self-checking bench for picorv32_mem_arbiter

module tb_picorv32_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance 0: round-robin, instance 1: fixed priority. Index [inst][master].
    logic [1:0][1:0]       mv, mi, mr;
    logic [1:0][1:0][31:0] ma, mw, mrd;
    logic [1:0][1:0][3:0]  ms;
    logic [1:0]            sv, si, sr;
    logic [1:0][31:0]      sa, sw, srd;
    logic [1:0][3:0]       ss;
    logic [1:0][1:0]       gr;
`ifdef MEM_ARB_TIMEOUT_EN
    logic [1:0]            terr;
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        picorv32_mem_arbiter #(
            .FIXED_PRIO(g)
`ifdef MEM_ARB_TIMEOUT_EN
            , .TIMEOUT_CYCLES(TO)
`endif
        ) dut (
            .clk(clk), .reset(reset),
            .m0_valid(mv[g][0]), .m0_instr(mi[g][0]), .m0_addr(ma[g][0]),
            .m0_wdata(mw[g][0]), .m0_wstrb(ms[g][0]), .m0_ready(mr[g][0]), .m0_rdata(mrd[g][0]),
            .m1_valid(mv[g][1]), .m1_instr(mi[g][1]), .m1_addr(ma[g][1]),
            .m1_wdata(mw[g][1]), .m1_wstrb(ms[g][1]), .m1_ready(mr[g][1]), .m1_rdata(mrd[g][1]),
            .s_valid(sv[g]), .s_instr(si[g]), .s_addr(sa[g]), .s_wdata(sw[g]), .s_wstrb(ss[g]),
            .s_ready(sr[g]), .s_rdata(srd[g]),
`ifdef MEM_ARB_TIMEOUT_EN
            .timeout_err(terr[g]),
`endif
            .grant(gr[g])
        );
    end

    // Memory responder controls
    int          mem_lat [2];
    logic [31:0] mem_data [2];
    bit          mem_never [2];
    bit          poke [2];
    int          rcnt [2];

    // Reference model: owner (-1 idle), last owner, captured request, busy-cycle count
    int          own [2] = '{-1, -1};
    int          last [2] = '{1, 1};
    int          cyc [2];
    logic [31:0] ca [2], cw [2];
    logic [3:0]  cs [2];
    logic        ci [2];
    bit          mterr [2];

    // Observed grant sequence per instance
    int          glog [2][8];
    int          gcnt [2];
    logic [1:0]  prev_gr [2];

    bit          c_busy, c_hit, c_own, c_rdy;

    function automatic void check(input string name, input int i, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h", name, i, act, exp);
        end
    endfunction

    // Memory: answers s_ready after mem_lat cycles of s_valid; noise on s_rdata otherwise.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sr = '0;
            rcnt = '{0, 0};
        end else begin
            #1;
            for (int i = 0; i < 2; i++) begin
                if (sv[i] && !sr[i]) begin
                    if (!mem_never[i] && rcnt[i] == mem_lat[i]) begin
                        sr[i] = 1'b1;
                        srd[i] = mem_data[i];
                        rcnt[i] = 0;
                    end else begin
                        rcnt[i]++;
                        srd[i] = $urandom;
                    end
                end else begin
                    sr[i] = poke[i];
                    srd[i] = $urandom;
                    rcnt[i] = 0;
                end
            end
        end
    end

    // Transaction-level model advanced on each clock edge
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                own[i] = -1;
                last[i] = 1;
                cyc[i] = 0;
                mterr[i] = 1'b0;
            end else if (own[i] < 0) begin
                if (mv[i][0] && mv[i][1]) own[i] = (i == 1) ? 0 : 1 - last[i];
                else if (mv[i][0]) own[i] = 0;
                else if (mv[i][1]) own[i] = 1;
                if (own[i] >= 0) begin
                    ca[i] = ma[i][own[i]];
                    cw[i] = mw[i][own[i]];
                    cs[i] = ms[i][own[i]];
                    ci[i] = mi[i][own[i]];
                    cyc[i] = 0;
                end
            end else if (sr[i]) begin
                last[i] = own[i];
                own[i] = -1;
            end else if (TO_EN && cyc[i] == TO - 1) begin
                last[i] = own[i];
                own[i] = -1;
                mterr[i] = 1'b1;
            end else begin
                cyc[i]++;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                c_busy = (own[i] >= 0);
                c_hit = TO_EN && c_busy && !sr[i] && (cyc[i] == TO - 1);
                check("s_valid", i, sv[i], c_busy);
                check("grant", i, gr[i], (own[i] == 0) ? 2'b01 : (own[i] == 1) ? 2'b10 : 2'b00);
                if (c_busy) begin
                    check("s_addr", i, sa[i], ca[i]);
                    check("s_wdata", i, sw[i], cw[i]);
                    check("s_wstrb", i, ss[i], cs[i]);
                    check("s_instr", i, si[i], ci[i]);
                end
                for (int k = 0; k < 2; k++) begin
                    c_own = (own[i] == k);
                    c_rdy = c_own && (sr[i] || c_hit);
                    check(k == 0 ? "m0_ready" : "m1_ready", i, mr[i][k], c_rdy);
                    if (!c_own || c_rdy)
                        check(k == 0 ? "m0_rdata" : "m1_rdata", i, mrd[i][k],
                              (c_own && sr[i]) ? srd[i] : 32'h0);
                end
`ifdef MEM_ARB_TIMEOUT_EN
                check("timeout_err", i, terr[i], mterr[i]);
`endif
                if (gr[i] != 2'b00 && prev_gr[i] == 2'b00 && gcnt[i] < 8) begin
                    glog[i][gcnt[i]] = gr[i];
                    gcnt[i]++;
                end
                prev_gr[i] = gr[i];
            end
        end
    end

    // Drive one request on master k of instance i, hold it until ready, then drop it.
    task automatic issue(input int i, input int k, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic ins,
                         output logic [31:0] rd, output int n);
        bit got;
        got = 1'b0;
        rd = '0;
        n = 0;
        ma[i][k] = a;
        mw[i][k] = d;
        ms[i][k] = s;
        mi[i][k] = ins;
        mv[i][k] = 1'b1;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (mr[i][k]) begin
                got = 1'b1;
                rd = mrd[i][k];
            end
        end
        check("ready_seen", i, got, 1'b1);
        @(posedge clk);
        #1;
        mv[i][k] = 1'b0;
    endtask

    task automatic check_log(input int i, input int n, input int e [8]);
        check("grant_count", i, gcnt[i], n);
        for (int j = 0; j < n; j++) check("grant_order", i, glog[i][j], e[j]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mv = '0;
        mem_lat = '{3, 3};
        mem_never = '{0, 0};
        poke = '{0, 0};
        gcnt = '{0, 0};
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [31:0] rdv [4];
    int          nv [4];

    initial begin
        mv = '0; mi = '0; ma = '0; mw = '0; ms = '0;
        srd = '0;
        mem_data = '{32'h0, 32'h0};
        prev_gr = '{2'b00, 2'b00};
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_s_valid", 0, sv, 2'b00);
        check("rst_grant", 0, {gr[1], gr[0]}, 4'b0000);
        check("rst_ready", 0, {mr[1], mr[0]}, 4'b0000);
        @(posedge clk);
        #1;

        // Single read: one arbitration cycle, then memory answers 3 cycles after s_valid
        mem_data[0] = 32'hDEADBEEF;
        issue(0, 0, 32'h0000_0010, 32'h0, 4'b0000, 1'b0, rdv[0], nv[0]);
        check("single_rdata", 0, rdv[0], 32'hDEADBEEF);
        check("single_latency", 0, nv[0], 5);

        // Simultaneous requests, round-robin: m0, IDLE, m1, twice
        do_reset();
        mem_data[0] = 32'hCAFE0001;
        repeat (2) begin
            fork
                issue(0, 0, 32'h100, 32'h11223344, 4'b1111, 1'b0, rdv[0], nv[0]);
                issue(0, 1, 32'h200, 32'h0, 4'b0000, 1'b0, rdv[1], nv[1]);
            join
        end
        check("rr_m1_rdata", 0, rdv[1], 32'hCAFE0001);
        check("rr_m1_latency", 0, nv[1], 10);
        check_log(0, 4, '{1, 2, 1, 2, 0, 0, 0, 0});

        // Continuous m0 traffic against a waiting m1 on both arbiters
        do_reset();
        fork
            repeat (4) issue(1, 0, 32'h40, 32'h1, 4'b0001, 1'b1, rdv[0], nv[0]);
            issue(1, 1, 32'h80, 32'h2, 4'b0010, 1'b0, rdv[1], nv[1]);
            repeat (4) issue(0, 0, 32'h44, 32'h3, 4'b0100, 1'b1, rdv[2], nv[2]);
            issue(0, 1, 32'h88, 32'h4, 4'b1000, 1'b0, rdv[3], nv[3]);
        join
        check_log(1, 5, '{1, 1, 1, 1, 2, 0, 0, 0});
        check_log(0, 5, '{1, 2, 1, 1, 1, 0, 0, 0});

        // Asynchronous reset in the middle of a BUSY1 transaction
        do_reset();
        mem_never[0] = 1'b1;
        mem_data[0] = 32'h0BADF00D;
        ma[0][1] = 32'h300;
        mv[0][1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ma[0][0] = 32'h400;
        mv[0][0] = 1'b1;
        @(negedge clk);
        check("pre_rst_s_valid", 0, sv[0], 1'b1);
        check("pre_rst_grant", 0, gr[0], 2'b10);
        #2;
        reset = 1'b1;
        #1;
        check("async_s_valid", 0, sv[0], 1'b0);
        check("async_grant", 0, gr[0], 2'b00);
        check("async_ready", 0, mr[0], 2'b00);
        mv[0][1] = 1'b0;
        mem_never[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(0, 0, 32'h400, 32'h0, 4'b0000, 1'b0, rdv[0], nv[0]);
        check("post_rst_rdata", 0, rdv[0], 32'h0BADF00D);
        check_log(0, 2, '{2, 1, 0, 0, 0, 0, 0, 0});

        // Forwarded request stays frozen while the masters' inputs churn
        do_reset();
        mem_lat[0] = 6;
        fork
            issue(0, 0, 32'h500, 32'hA5A55A5A, 4'b0011, 1'b1, rdv[0], nv[0]);
            begin
                repeat (6) begin
                    @(posedge clk);
                    #2;
                    ma[0][0] = $urandom; mw[0][0] = $urandom; ms[0][0] = 4'($urandom);
                    ma[0][1] = $urandom; mw[0][1] = $urandom; ms[0][1] = 4'($urandom);
                    mi[0] = 2'($urandom);
                end
                @(negedge clk);
                check("hold_s_addr", 0, sa[0], 32'h500);
                check("hold_s_wdata", 0, sw[0], 32'hA5A55A5A);
                check("hold_s_wstrb", 0, ss[0], 4'b0011);
                check("hold_s_instr", 0, si[0], 1'b1);
            end
        join

        // s_ready while IDLE is ignored
        do_reset();
        poke[1] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_ready", 1, mr[1], 2'b00);
        end
        poke[1] = 1'b0;
        @(posedge clk);
        #1;

        // s_ready arriving on the 8th BUSY cycle completes normally
        do_reset();
        mem_lat[0] = 7;
        mem_data[0] = 32'h55AA00FF;
        issue(0, 0, 32'h20, 32'h0, 4'b0000, 1'b0, rdv[0], nv[0]);
        check("late_rdata", 0, rdv[0], 32'h55AA00FF);
        check("late_latency", 0, nv[0], 9);
`ifdef MEM_ARB_TIMEOUT_EN
        check("late_no_timeout", 0, terr[0], 1'b0);

        // Memory never answers: abort on the 8th BUSY cycle with zero data
        do_reset();
        mem_never[0] = 1'b1;
        mem_data[0] = 32'h12345678;
        issue(0, 0, 32'h600, 32'h0, 4'b0000, 1'b0, rdv[0], nv[0]);
        check("to_rdata", 0, rdv[0], 32'h0);
        check("to_latency", 0, nv[0], 9);
        check("to_err_set", 0, terr[0], 1'b1);
        mem_never[0] = 1'b0;
        issue(0, 1, 32'h700, 32'h0, 4'b0000, 1'b0, rdv[1], nv[1]);
        check("after_to_rdata", 0, rdv[1], 32'h12345678);
        check("after_to_latency", 0, nv[1], 5);
        check("to_err_sticky", 0, terr[0], 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
